mac_pipe: RTL and testbench

- Parametrised, pipelined signed multiply-accumulate unit for the accelerator datapath.
- Successor to the fixed 8x8 combinational Baugh-Wooley multiplier: generalised operand width, registered product pipeline of configurable depth, and a wide accumulator.
- Supports single products and multi-element dot products, with valid/ready handshakes on both sides.
- Sits between the operand fetch stage and the result writeback buffer.

---
 rtl/mac_pipe.sv | 177 +++++++++++++++++
 tb/tb_mac_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipe.sv
// Pipelined signed multiply-accumulate: operand register, STAGES product registers, accumulator/result register.
// Optional MAC_SAT_EN: saturating accumulation with a sticky per-accumulation ovf flag (wraps, ovf=0 otherwise).
module mac_pipe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     first,
    input  logic                     last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  result,
    output logic                     ovf
);
    localparam int PW = 2 * DATA_W;

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic [ACC_W:0] sum_w;
`endif

    logic stall;

    logic                     op_vld_q, op_vld_d;
    logic                     op_first_q, op_first_d;
    logic                     op_last_q, op_last_d;
    logic signed [DATA_W-1:0] op_a_q, op_a_d;
    logic signed [DATA_W-1:0] op_b_q, op_b_d;

    logic signed [PW-1:0] a_ext, b_ext, prod;

    logic [STAGES-1:0]         pv_q, pv_d;
    logic [STAGES-1:0]         pf_q, pf_d;
    logic [STAGES-1:0]         pl_q, pl_d;
    logic [STAGES-1:0][PW-1:0] pp_q, pp_d;

    logic                    tail_vld, tail_first, tail_last;
    logic signed [ACC_W-1:0] tail_p, acc_base, acc_next;
    logic                    sat_hit;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    acc_ovf_q, acc_ovf_d;
    logic signed [ACC_W-1:0] result_q, result_d;
    logic                    out_valid_q, out_valid_d;
    logic                    ovf_q, ovf_d;

    // A result waiting on downstream freezes every stage, so nothing is ever dropped.
    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        op_vld_d   = op_vld_q;
        op_first_d = op_first_q;
        op_last_d  = op_last_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        if (!stall) begin
            op_vld_d   = in_valid;
            op_first_d = first;
            op_last_d  = last;
            op_a_d     = a;
            op_b_d     = b;
        end
    end

    always_comb begin
        a_ext = {{DATA_W{op_a_q[DATA_W-1]}}, op_a_q};
        b_ext = {{DATA_W{op_b_q[DATA_W-1]}}, op_b_q};
        prod  = a_ext * b_ext;
    end

    always_comb begin
        pv_d = pv_q;
        pf_d = pf_q;
        pl_d = pl_q;
        pp_d = pp_q;
        if (!stall) begin
            pv_d[0] = op_vld_q;
            pf_d[0] = op_first_q;
            pl_d[0] = op_last_q;
            pp_d[0] = prod;
            for (int unsigned i = 1; i < STAGES; i++) begin
                pv_d[i] = pv_q[i-1];
                pf_d[i] = pf_q[i-1];
                pl_d[i] = pl_q[i-1];
                pp_d[i] = pp_q[i-1];
            end
        end
    end

    assign tail_vld   = pv_q[STAGES-1];
    assign tail_first = pf_q[STAGES-1];
    assign tail_last  = pl_q[STAGES-1];
    assign tail_p     = ACC_W'($signed(pp_q[STAGES-1]));

    always_comb begin
        acc_base = tail_first ? '0 : acc_q;
`ifdef MAC_SAT_EN
        // One extra bit exposes overflow: top two bits disagree only when the true sum is out of range.
        sum_w   = {acc_base[ACC_W-1], acc_base} + {tail_p[ACC_W-1], tail_p};
        sat_hit = (sum_w[ACC_W] != sum_w[ACC_W-1]);
        if (sat_hit) begin
            acc_next = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = sum_w[ACC_W-1:0];
        end
`else
        acc_next = acc_base + tail_p;
        sat_hit  = 1'b0;
`endif
    end

    always_comb begin
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (!stall) begin
            out_valid_d = tail_vld && tail_last;
            if (tail_vld) begin
                acc_d     = acc_next;
                acc_ovf_d = (tail_first ? 1'b0 : acc_ovf_q) | sat_hit;
                if (tail_last) begin
                    result_d = acc_next;
                    ovf_d    = acc_ovf_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_vld_q    <= 1'b0;
            op_first_q  <= 1'b0;
            op_last_q   <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            pv_q        <= '0;
            pf_q        <= '0;
            pl_q        <= '0;
            pp_q        <= '0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            op_vld_q    <= op_vld_d;
            op_first_q  <= op_first_d;
            op_last_q   <= op_last_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            pv_q        <= pv_d;
            pf_q        <= pf_d;
            pl_q        <= pl_d;
            pp_q        <= pp_d;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: directed literal cases plus random traffic against a queue-based accumulator model.
// Two instances (ACC_W=32 and ACC_W=16) share stimulus; honours MAC_SAT_EN like the design.
module tb_mac_pipe;
    localparam int DW  = 8;
    localparam int AW  = 32;
    localparam int AWS = 16;
    localparam int ST  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic first = 1'b0;
    logic last = 1'b0;
    logic out_ready = 1'b1;
    logic signed [DW-1:0] a = '0;
    logic signed [DW-1:0] b = '0;

    logic in_ready, out_valid, ovf;
    logic in_ready_s, out_valid_s, ovf_s;
    logic signed [AW-1:0]  result;
    logic signed [AWS-1:0] result_s;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    mac_pipe #(.DATA_W(DW), .ACC_W(AW), .STAGES(ST)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .first(first), .last(last),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf)
    );

    mac_pipe #(.DATA_W(DW), .ACC_W(AWS), .STAGES(ST)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .first(first), .last(last),
        .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s), .ovf(ovf_s)
    );

    typedef struct {
        longint r;
        longint rs;
        bit     o;
        bit     os;
    } exp_t;

    exp_t   exp_q[$];
    longint m_acc   = 0;
    longint m_acc_s = 0;
    bit     m_stk   = 1'b0;
    bit     m_stk_s = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint acc_step(input longint acc, input longint p, input bit f,
                                        input int w, output bit hit);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        longint s  = (f ? 0 : acc) + p;
        hit = 1'b0;
`ifdef MAC_SAT_EN
        if (s > hi) begin
            s = hi;
            hit = 1'b1;
        end else if (s < lo) begin
            s = lo;
            hit = 1'b1;
        end
`else
        s = s & ((longint'(1) <<< w) - 1);
        if (s > hi) s = s - (longint'(1) <<< w);
`endif
        return s;
    endfunction

    // Model: every accepted beat updates the sums; a last beat queues its expected result.
    always @(posedge clk) begin
        longint p;
        bit     h;
        if (rst) begin
            exp_q.delete();
            m_acc   = 0;
            m_acc_s = 0;
            m_stk   = 1'b0;
            m_stk_s = 1'b0;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                p       = longint'(a) * longint'(b);
                m_acc   = acc_step(m_acc, p, first, AW, h);
                m_stk   = (first ? 1'b0 : m_stk) | h;
                m_acc_s = acc_step(m_acc_s, p, first, AWS, h);
                m_stk_s = (first ? 1'b0 : m_stk_s) | h;
                if (last) exp_q.push_back('{m_acc, m_acc_s, m_stk, m_stk_s});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            check("lockstep_in_ready", in_ready_s, in_ready);
            check("lockstep_out_valid", out_valid_s, out_valid);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    check("model_result", result, exp_q[0].r);
                    check("model_result16", result_s, exp_q[0].rs);
                    check("model_ovf", ovf, exp_q[0].o);
                    check("model_ovf16", ovf_s, exp_q[0].os);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ia, input int ib, input logic f, input logic l);
        int n = 0;
        in_valid = 1'b1;
        a = DW'(ia);
        b = DW'(ib);
        first = f;
        last = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input longint r, input longint rs);
        check({name, "_valid"}, out_valid, 1);
        check(name, result, r);
        check({name, "_16"}, result_s, rs);
    endtask

    initial begin
        int n;
        tick(3);
        rst = 1'b0;
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_ovf", ovf, 0);
        check("reset_in_ready", in_ready, 1);

        // first=0 on the very first beat adds to a cleared accumulator
        send(3, 4, 1'b0, 1'b1);
        tick(3);
        expect_out("first0_after_reset", 12, 12);

        // plain multiplies and latency
        send(2, 3, 1'b1, 1'b1);
        check("lat_k0", out_valid, 0);
        tick(1);
        check("lat_k1", out_valid, 0);
        tick(1);
        check("lat_k2", out_valid, 0);
        tick(1);
        expect_out("mul_2x3", 6, 6);
        send(-128, -1, 1'b1, 1'b1);
        tick(3);
        expect_out("mul_m128xm1", 128, 128);
        send(-128, -128, 1'b1, 1'b1);
        tick(3);
        expect_out("mul_m128sq", 16384, 16384);

        // dot product back-to-back, then with bubbles
        send(1, 1, 1'b1, 1'b0);
        send(-1, -1, 1'b0, 1'b0);
        send(127, -1, 1'b0, 1'b0);
        send(-128, 1, 1'b0, 1'b1);
        tick(2);
        check("dot_not_early", out_valid, 0);
        tick(1);
        expect_out("dot4", -253, -253);
        send(1, 1, 1'b1, 1'b0);
        tick(2);
        send(-1, -1, 1'b0, 1'b0);
        tick(1);
        send(127, -1, 1'b0, 1'b0);
        tick(3);
        send(-128, 1, 1'b0, 1'b1);
        tick(3);
        expect_out("dot4_bubbles", -253, -253);

        // open sum discarded by a new first beat
        send(5, 5, 1'b1, 1'b0);
        send(2, 2, 1'b1, 1'b1);
        tick(3);
        expect_out("discard_open", 4, 4);

        // back-to-back results
        send(2, 3, 1'b1, 1'b1);
        send(10, 1, 1'b1, 1'b1);
        send(-1, -1, 1'b1, 1'b1);
        tick(1);
        expect_out("b2b_0", 6, 6);
        tick(1);
        expect_out("b2b_1", 10, 10);
        tick(1);
        expect_out("b2b_2", 1, 1);
        tick(1);
        check("b2b_drop", out_valid, 0);

        // backpressure
        out_ready = 1'b0;
        send(2, 3, 1'b1, 1'b1);
        send(4, 5, 1'b1, 1'b1);
        tick(2);
        expect_out("bp_first", 6, 6);
        check("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            expect_out("bp_hold", 6, 6);
            check("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick(1);
        expect_out("bp_next", 20, 20);
        tick(1);
        check("bp_drain", out_valid, 0);

        // reset mid dot product
        send(7, 7, 1'b1, 1'b0);
        send(3, 3, 1'b0, 1'b0);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_result", result, 0);
        check("rst_mid_in_ready", in_ready, 1);
        send(2, 3, 1'b0, 1'b1);
        tick(3);
        expect_out("rst_acc_cleared", 6, 6);
        send(2, 3, 1'b1, 1'b1);
        tick(3);
        expect_out("rst_then_mul", 6, 6);
        send(9, 9, 1'b1, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);
        check("rst_inflight_dropped", out_valid, 0);

        // 16-bit accumulator overflow
        send(127, 127, 1'b1, 1'b0);
        send(127, 127, 1'b0, 1'b0);
        send(127, 127, 1'b0, 1'b1);
        tick(3);
`ifdef MAC_SAT_EN
        expect_out("ovf3", 48387, 32767);
        check("ovf3_flag16", ovf_s, 1);
`else
        expect_out("ovf3", 48387, -17149);
        check("ovf3_flag16", ovf_s, 0);
`endif
        check("ovf3_flag32", ovf, 0);
        send(1, 1, 1'b1, 1'b1);
        tick(3);
        expect_out("ovf_cleared", 1, 1);
        check("ovf_cleared_flag16", ovf_s, 0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = DW'($urandom_range(0, 255));
            b         = DW'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = DW'(-128);
            first     = ($urandom_range(0, 4) == 0);
            last      = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        tick(2);
        check("idle_out_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
